// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the wait-stated data-memory responder.
// Holds the FSM state encoding, the default geometry and the word-index width helper.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_DEPTH_WORDS = 64;
    localparam int DEF_WAIT_STATES = 2;

    function automatic int idx_w(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: synchronous write, asynchronous read port,
// synchronous clear on reset and byte taps of word 0 for the demo display.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int IDX_W       = idx_w(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o,
    output logic [7:0]       mem0_o,
    output logic [7:0]       mem1_o,
    output logic [7:0]       mem2_o,
    output logic [7:0]       mem3_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
    assign mem0_o  = mem_q[0][7:0];
    assign mem1_o  = mem_q[0][15:8];
    assign mem2_o  = mem_q[0][23:16];
    assign mem3_o  = mem_q[0][31:24];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: accepts one load/store, holds busy through the
// configured wait states, then commits the store or returns the load word in DONE.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic [7:0]  mem0,
    output logic [7:0]  mem1,
    output logic [7:0]  mem2,
    output logic [7:0]  mem3
);

    localparam int          IDX_W    = idx_w(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        err_q;

    logic             acc_write;
    logic [31:2]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_oor;
    logic             done_entry;
    logic             arr_we;
    logic [31:0]      arr_rdata;
    logic             unused_addr_lsb;

    // Word access only; the byte offset has no meaning here.
    assign unused_addr_lsb = ^req_addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    busy    = 1'b1;
                    cnt_d   = WAIT_CNT;
                    state_d = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states DONE is entered from the accept cycle itself, so the
    // access must come straight from the request rather than the latched copy.
    assign acc_write  = (state_q == IDLE) ? req_write       : wr_q;
    assign acc_addr   = (state_q == IDLE) ? req_addr[31:2]  : addr_q;
    assign acc_wdata  = (state_q == IDLE) ? req_wdata       : wdata_q;
    assign acc_idx    = acc_addr[IDX_W+1:2];
    assign acc_oor    = |acc_addr[31:IDX_W+2];
    assign done_entry = (state_d == DONE);
    assign arr_we     = done_entry && acc_write && !acc_oor && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rdata_valid_q <= done_entry && !acc_write;
            err_q         <= done_entry && acc_oor;
            if (done_entry && !acc_write) begin
                rdata_q <= acc_oor ? 32'h0 : arr_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr[31:2];
            wdata_q <= req_wdata;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (arr_we),
        .waddr_i (acc_idx),
        .wdata_i (acc_wdata),
        .raddr_i (acc_idx),
        .rdata_o (arr_rdata),
        .mem0_o  (mem0),
        .mem1_o  (mem1),
        .mem2_o  (mem2),
        .mem3_o  (mem3)
    );

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a 2-wait-state instance for the main
// load/store/range/reset sequence and a 0-wait-state instance for streaming loads.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        busy, rdata_valid, err;
    logic [31:0] rdata;
    logic [7:0]  mem0, mem1, mem2, mem3;

    logic        r0_valid, r0_write;
    logic [31:0] r0_addr, r0_wdata;
    logic        busy0, rdata_valid0, err0;
    logic [31:0] rdata0;
    logic [7:0]  m0_0, m0_1, m0_2, m0_3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        e;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(r0_valid), .req_write(r0_write),
        .req_addr(r0_addr), .req_wdata(r0_wdata),
        .busy(busy0), .rdata(rdata0), .rdata_valid(rdata_valid0), .err(err0),
        .mem0(m0_0), .mem1(m0_1), .mem2(m0_2), .mem3(m0_3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] d, input logic e);
        exp_t x;
        x.vld  = v;
        x.data = d;
        x.e    = e;
        return x;
    endfunction

    // Completion monitor for the 2-wait-state instance
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && (rdata_valid || err)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {30'b0, rdata_valid, err}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_valid", {31'b0, rdata_valid}, {31'b0, e.vld});
                chk("sb_err", {31'b0, err}, {31'b0, e.e});
                if (e.vld) chk("sb_rdata", rdata, e.data);
            end
        end
    end

    // Drives one request and returns at the negedge of its DONE cycle.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, 32'd3);
        if (w) chk({tag, "_no_rvalid"}, {31'b0, rdata_valid}, 32'h0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        logic exp_busy;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        r0_valid = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvalid", {31'b0, rdata_valid}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_taps", {mem3, mem2, mem1, mem0}, 32'h0);
        chk("rst_busy0", {31'b0, busy0}, 32'h0);

        access(1'b1, 32'h0, 32'hDEADBEEF, "st0");
        chk("st0_taps", {mem3, mem2, mem1, mem0}, 32'hDEADBEEF);
        idle();

        sb.push_back(mk(1'b1, 32'hDEADBEEF, 1'b0));
        access(1'b0, 32'h0, 32'h0, "ld0");
        chk("ld0_busy_low", {31'b0, busy}, 32'h0);
        idle();

        access(1'b1, 32'h8, 32'h11223344, "st8");
        sb.push_back(mk(1'b1, 32'h11223344, 1'b0));
        access(1'b0, 32'hA, 32'h0, "ldA");
        idle();

        sb.push_back(mk(1'b0, 32'h0, 1'b1));
        access(1'b1, 32'h100, 32'hFFFFFFFF, "st_oor");
        chk("oor_rdata_hold", rdata, 32'h11223344);
        chk("oor_taps", {mem3, mem2, mem1, mem0}, 32'hDEADBEEF);
        sb.push_back(mk(1'b1, 32'hDEADBEEF, 1'b0));
        access(1'b0, 32'h0, 32'h0, "ld0_after_oor");
        sb.push_back(mk(1'b1, 32'h0, 1'b1));
        access(1'b0, 32'h100, 32'h0, "ld_oor");
        idle();

        // Reset lands in the second WAIT cycle of a store to word 1
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h55AA55AA;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait_busy", {31'b0, busy}, 32'h1);
        #1 reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_rvalid", {31'b0, rdata_valid}, 32'h0);
            chk("abort_err", {31'b0, err}, 32'h0);
            @(negedge clk);
        end
        sb.push_back(mk(1'b1, 32'h0, 1'b0));
        access(1'b0, 32'h4, 32'h0, "ld4_after_abort");
        sb.push_back(mk(1'b1, 32'h0, 1'b0));
        access(1'b0, 32'h0, 32'h0, "ld0_after_abort");
        idle();
        chk("abort_taps", {mem3, mem2, mem1, mem0}, 32'h0);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'h0);

        // Zero wait states: one-cycle store, then a continuously held load
        @(posedge clk); #1;
        r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 32'h0; r0_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("ws0_st_busy", {31'b0, busy0}, 32'h1);
        @(posedge clk); #1;
        r0_write = 1'b0;
        @(negedge clk);
        chk("ws0_st_done_busy", {31'b0, busy0}, 32'h0);
        chk("ws0_st_taps", {m0_3, m0_2, m0_1, m0_0}, 32'hCAFEF00D);
        chk("ws0_st_no_rvalid", {31'b0, rdata_valid0}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_busy = (i % 2 == 0);
            chk("ws0_busy", {31'b0, busy0}, {31'b0, exp_busy});
            chk("ws0_rvalid", {31'b0, rdata_valid0}, {31'b0, !exp_busy});
            if (rdata_valid0) begin
                pulses++;
                chk("ws0_rdata", rdata0, 32'hCAFEF00D);
            end
        end
        chk("ws0_pulses", pulses, 32'd4);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core's memory stage: accepts one load or store per request from the M stage, inserts a parameterised number of wait states, and commits the store or returns the load word. While an access is in flight it asserts `busy`, which the hazard unit treats as a memory-stage stall request that freezes F/D/E/M. It replaces the single-cycle data memory and keeps the `mem0..mem3` demonstration byte taps.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, ≥4.
- `WAIT_STATES`, 2: wait cycles per access; 0..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: M stage holds a load or store (MemWriteM or MemtoRegM).
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address (ALU result of M stage).
- `req_wdata` in 32: store data.
- `busy` out 1: stall request to the hazard unit.
- `rdata` out 32: registered load data.
- `rdata_valid` out 1: one-cycle pulse; `rdata` is new this cycle.
- `err` out 1: one-cycle pulse; out-of-range access completed this cycle.
- `mem0..mem3` out 8 each: bytes 0..3 (LSB first) of word 0.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, `req_valid`=0: stay; `busy`=0.
- IDLE, `req_valid`=1: `busy`=1 combinationally; latch write/addr/wdata; `cnt`←`WAIT_STATES`; next state WAIT, or DONE when `WAIT_STATES`=0.
- WAIT: `busy`=1; `cnt` decrements each cycle; at `cnt`=1, next DONE.
- Entry into DONE (same edge): store writes the latched word; load sets `rdata` ← word.
- DONE: `busy`=0, `rdata_valid`=1 for a load, `err`=1 if out of range; next IDLE unconditionally. The request still present in DONE is not re-accepted; the pipeline advances at the end of DONE.
- Indexing: word index = `req_addr[log2(DEPTH_WORDS)+1:2]`; `req_addr[1:0]` ignored (word access only).
- Out of range: any of `req_addr[31:log2(DEPTH_WORDS)+2]` nonzero. Stores dropped; loads return 0; `err` pulses in DONE.
- Stores leave `rdata` unchanged.
- The initiator holds the request inputs stable while `busy`=1. Inputs are latched in IDLE, so later changes are ignored.
- Reset: state IDLE, `cnt`=0, `rdata`=0, `rdata_valid`=0, `err`=0, all memory words zeroed, so `mem0..mem3`=0.
- Reset during WAIT: access aborted, no write, no pulse.
- Reset in the cycle of the DONE-entry edge: reset wins, no write.

## Timing
- Per access: `busy` high for `WAIT_STATES`+1 cycles (IDLE accept cycle plus WAIT cycles), then one DONE cycle with `busy`=0.
- Occupancy: `WAIT_STATES`+2 cycles. Minimum is 2 cycles at `WAIT_STATES`=0.
- Load data visible in DONE, registered at the DONE-entry edge, and held until the next load completes.
- Store visible on `mem0..mem3` (if word 0) from DONE onward.
- Back-to-back requests: the next request is accepted in the IDLE cycle following DONE. Throughput is one access per `WAIT_STATES`+2 cycles.
- `busy` has a combinational path from `req_valid` in IDLE only. All other outputs are registered.

## Structure
- Shared package: FSM state enum (IDLE/WAIT/DONE), default `DEPTH_WORDS`/`WAIT_STATES`, address-index width function.
- Sub-module `dmem_array`: storage with synchronous write, one read port, synchronous clear on reset, word-0 byte taps.
- FSM, counter and range check live in `dmem_responder`.

## Test plan
- `WAIT_STATES`=2; store 0xDEADBEEF at 0x0 → `busy` high 3 cycles, then DONE; `mem0..mem3` = EF,BE,AD,DE from DONE; no `rdata_valid`.
- Load from 0x0 after the above → `rdata`=0xDEADBEEF with `rdata_valid` pulse exactly 3 cycles after the request appears; `busy` low in that cycle.
- Store 0x11223344 at 0x8 then immediate load from 0xA → load returns 0x11223344 (low address bits ignored). Second request accepted the cycle after first DONE.
- `DEPTH_WORDS`=64; store 0xFFFFFFFF at 0x100 → `err` pulses in DONE; subsequent load at 0x0 and 0x100 return unchanged data and 0 respectively.
- Reset asserted during the second WAIT cycle of a store to 0x4 → state IDLE, `busy`=0 next cycle, word 1 reads 0, no `err`/`rdata_valid`.
- `WAIT_STATES`=0; load with `req_valid` held high continuously → alternating IDLE(busy=1)/DONE(busy=0) cycles, one `rdata_valid` per 2 cycles.
